// File: rtl/aes_p2s_pkg.sv
// Shared types and helpers for the AES/DES parallel-to-serial stream converter.
// Holds the FSM state encoding and the lane-counter width function.
package aes_p2s_pkg;

    typedef enum logic [0:0] {
        P2S_IDLE,
        P2S_SHIFT
    } p2s_state_t;

    // Width of the lane counter: ceil(log2(lanes)), but never narrower than one bit.
    function automatic int p2s_cnt_w(input int lanes);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < lanes) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/aes_stream_serializer.sv
// Parallel-to-serial converter: one LANES*DATA_W word in, LANES beats of DATA_W out.
// Define AES_P2S_BACK2BACK_EN to accept the next word on the last-beat handshake (no bubble).
module aes_stream_serializer
    import aes_p2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(LANES+1)-1:0] out_remaining
);

    localparam int CNT_W = p2s_cnt_w(LANES);
    localparam int REM_W = $clog2(LANES + 1);

`ifdef AES_P2S_BACK2BACK_EN
    localparam bit BACK2BACK = 1'b1;
`else
    localparam bit BACK2BACK = 1'b0;
`endif

    p2s_state_t        state;
    p2s_state_t        state_nxt;
    logic [DATA_W-1:0] shift_reg [LANES];
    logic [DATA_W-1:0] load_lanes [LANES];
    logic [CNT_W-1:0]  lane_cnt;
    logic              last_lane;
    logic              beat;
    logic              load;

    assign last_lane = (lane_cnt == CNT_W'(LANES - 1));
    assign beat      = out_valid && out_ready;
    assign load      = in_valid && in_ready;

    // Abort and reset both veto acceptance so a word can never slip in alongside them.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !abort) begin
            in_ready = (state == P2S_IDLE) || (BACK2BACK && beat && last_lane);
        end
    end

    // Reorder the incoming word so that slot 0 always holds the first lane to be emitted.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            load_lanes[k] = '0;
            if (MSB_FIRST) begin
                load_lanes[k] = in_data[(LANES-1-k)*DATA_W +: DATA_W];
            end else begin
                load_lanes[k] = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= P2S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            P2S_IDLE: begin
                if (load) begin
                    state_nxt = P2S_SHIFT;
                end
            end
            P2S_SHIFT: begin
                if (abort) begin
                    state_nxt = P2S_IDLE;
                end else if (beat && last_lane) begin
                    state_nxt = load ? P2S_SHIFT : P2S_IDLE;
                end
            end
            default: state_nxt = P2S_IDLE;
        endcase
    end

    // A load on the last-beat handshake takes priority over advancing the drained word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            for (int k = 0; k < LANES; k++) begin
                shift_reg[k] <= '0;
            end
        end else if (abort) begin
            lane_cnt <= '0;
        end else if (load) begin
            lane_cnt <= '0;
            for (int k = 0; k < LANES; k++) begin
                shift_reg[k] <= load_lanes[k];
            end
        end else if (beat) begin
            if (!last_lane) begin
                lane_cnt <= lane_cnt + CNT_W'(1);
            end else begin
                lane_cnt <= '0;
            end
            for (int k = 0; k < LANES - 1; k++) begin
                shift_reg[k] <= shift_reg[k+1];
            end
            shift_reg[LANES-1] <= '0;
        end
    end

    always_comb begin
        out_valid     = (state == P2S_SHIFT);
        out_data      = shift_reg[0];
        out_last      = 1'b0;
        out_remaining = '0;
        if (state == P2S_SHIFT) begin
            out_last      = last_lane;
            out_remaining = REM_W'(LANES) - REM_W'(lane_cnt);
        end
    end

endmodule

// File: tb/tb_aes_stream_serializer.sv
// Directed testbench for aes_stream_serializer: table-driven cycles plus reset and 16-lane MSB-first sequences.
// Expectations follow AES_P2S_BACK2BACK_EN when it is defined for the build.
module tb_aes_stream_serializer;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int RW = $clog2(LN + 1);
    localparam int WL = 16;
    localparam int WRW = $clog2(WL + 1);

`ifdef AES_P2S_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           abort, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [LN*DW-1:0] in_data;
    logic [DW-1:0]  out_data;
    logic [RW-1:0]  out_remaining;

    logic           w_abort, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last;
    logic [WL*DW-1:0] w_in_data;
    logic [DW-1:0]  w_out_data;
    logic [WRW-1:0] w_out_remaining;

    aes_stream_serializer #(.DATA_W(DW), .LANES(LN), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_remaining(out_remaining)
    );

    aes_stream_serializer #(.DATA_W(DW), .LANES(WL), .MSB_FIRST(1'b1)) dut_wide (
        .clk(clk), .rst(rst), .abort(w_abort),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_last(w_out_last), .out_remaining(w_out_remaining)
    );

    typedef struct {
        logic          in_valid;
        logic [31:0]   in_data;
        logic          out_ready;
        logic          abort;
        logic          exp_valid;
        logic          chk_data;
        logic [7:0]    exp_data;
        logic          exp_last;
        logic [RW-1:0] exp_rem;
        logic          exp_in_ready;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [31:0] WORD_A = 32'h33221100;
    localparam logic [31:0] WORD_B = 32'h77665544;

    function automatic vec_t mk(input logic iv, input logic [31:0] idata, input logic rdy,
                                input logic ab, input logic ev, input logic cd,
                                input logic [7:0] ed, input logic el, input logic [RW-1:0] er,
                                input logic eir);
        vec_t v;
        v.in_valid = iv; v.in_data = idata; v.out_ready = rdy; v.abort = ab;
        v.exp_valid = ev; v.chk_data = cd; v.exp_data = ed; v.exp_last = el;
        v.exp_rem = er; v.exp_in_ready = eir;
        return v;
    endfunction

    task automatic check1(input string name, input int row, input logic [31:0] act,
                          input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid  = v.in_valid;
        in_data   = v.in_data;
        out_ready = v.out_ready;
        abort     = v.abort;
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        check1("out_valid", row, 32'(out_valid), 32'(v.exp_valid));
        if (v.chk_data) begin
            check1("out_data", row, 32'(out_data), 32'(v.exp_data));
        end
        check1("out_last", row, 32'(out_last), 32'(v.exp_last));
        check1("out_remaining", row, 32'(out_remaining), 32'(v.exp_rem));
        check1("in_ready", row, 32'(in_ready), 32'(v.exp_in_ready));
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_abort = 1'b0; w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;

        // Reset state while rst is held, with in_valid high to prove in_ready stays low.
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check1("rst.out_valid", -1, 32'(out_valid), 32'd0);
        check1("rst.out_data", -1, 32'(out_data), 32'd0);
        check1("rst.out_last", -1, 32'(out_last), 32'd0);
        check1("rst.out_remaining", -1, 32'(out_remaining), 32'd0);
        check1("rst.in_ready", -1, 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Plain word, sink always ready.
        vecs.push_back(mk(1, WORD_A, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h00, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h22, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h33, 1, 1, B2B));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        // Sink stalls three cycles while lane 1 is presented.
        vecs.push_back(mk(1, WORD_A, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h00, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h22, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h33, 1, 1, B2B));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        // Abort on lane 2 with a competing word offered in the same cycle.
        vecs.push_back(mk(1, WORD_A, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h00, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(1, WORD_B, 1, 1, 1, 1, 8'h22, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1));
        // Two words offered back to back with in_valid held.
        vecs.push_back(mk(1, WORD_A, 1, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, WORD_B, 1, 0, 1, 1, 8'h00, 0, 4, 0));
        vecs.push_back(mk(1, WORD_B, 1, 0, 1, 1, 8'h11, 0, 3, 0));
        vecs.push_back(mk(1, WORD_B, 1, 0, 1, 1, 8'h22, 0, 2, 0));
        if (B2B) begin
            vecs.push_back(mk(1, WORD_B, 1, 0, 1, 1, 8'h33, 1, 1, 1));
        end else begin
            vecs.push_back(mk(1, WORD_B, 1, 0, 1, 1, 8'h33, 1, 1, 0));
            vecs.push_back(mk(1, WORD_B, 1, 0, 0, 1, 8'h00, 0, 0, 1));
        end
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h44, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h55, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h66, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h77, 1, 1, B2B));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Asynchronous reset pulse while lane 1 is presented.
        @(negedge clk);
        in_valid = 1'b1; in_data = WORD_A; out_ready = 1'b1; abort = 1'b0;
        #1;
        check1("rstpulse.accept", 0, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check1("rstpulse.lane0", 1, 32'(out_data), 32'h00);
        @(negedge clk);
        #1;
        check1("rstpulse.lane1", 2, 32'(out_data), 32'h11);
        rst = 1'b1; in_valid = 1'b1;
        #1;
        check1("rstpulse.out_valid", 3, 32'(out_valid), 32'd0);
        check1("rstpulse.out_data", 3, 32'(out_data), 32'd0);
        check1("rstpulse.out_remaining", 3, 32'(out_remaining), 32'd0);
        check1("rstpulse.in_ready", 3, 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check1("rstpulse.in_ready_after", 4, 32'(in_ready), 32'd1);
        check1("rstpulse.idle", 4, 32'(out_valid), 32'd0);

        // 16-lane MSB-first instance: lane k holds value k, expect 0F down to 00.
        for (int k = 0; k < WL; k++) begin
            w_in_data[k*DW +: DW] = 8'(k);
        end
        @(negedge clk);
        w_in_valid = 1'b1;
        #1;
        check1("wide.in_ready", 0, 32'(w_in_ready), 32'd1);
        @(negedge clk);
        w_in_valid = 1'b0;
        for (int i = 0; i < WL; i++) begin
            #1;
            check1("wide.out_valid", i, 32'(w_out_valid), 32'd1);
            check1("wide.out_data", i, 32'(w_out_data), 32'(WL - 1 - i));
            check1("wide.out_last", i, 32'(w_out_last), (i == WL - 1) ? 32'd1 : 32'd0);
            check1("wide.out_remaining", i, 32'(w_out_remaining), 32'(WL - i));
            @(negedge clk);
        end
        #1;
        check1("wide.done_valid", WL, 32'(w_out_valid), 32'd0);
        check1("wide.done_remaining", WL, 32'(w_out_remaining), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
